alu_dec_queue: RTL

//  Buffered, handshaked successor to the per-instruction ALU decoder: accepts fetched
//  {pc, inst} words, decodes each into an 8-bit alucontrol plus class flags, and holds the

---
 rtl/alu_dec_queue_pkg.sv | 147 ++++++++++++++
 rtl/alu_dec_core.sv | 125 ++++++++++++
 rtl/alu_dec_queue.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_dec_queue_pkg.sv
// Shared types and encodings for the buffered ALU decode queue.
//   - opcode / funct / REGIMM rt / COP0 rs codes of the MIPS instruction word
//   - EXE_*_OP alucontrol codes produced by decode
//   - dec_t: decoded payload stored in each queue entry
package alu_dec_queue_pkg;

    localparam int unsigned INST_W    = 32;
    localparam int unsigned DEC_ALU_W = 8;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SW      = 6'b101011;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_SRL     = 6'b000010;
    localparam logic [5:0] FN_SRA     = 6'b000011;
    localparam logic [5:0] FN_SLLV    = 6'b000100;
    localparam logic [5:0] FN_SRLV    = 6'b000110;
    localparam logic [5:0] FN_SRAV    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_MOVZ    = 6'b001010;
    localparam logic [5:0] FN_MOVN    = 6'b001011;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_BREAK   = 6'b001101;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MTHI    = 6'b010001;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_MTLO    = 6'b010011;
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_MULTU   = 6'b011001;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_DIVU    = 6'b011011;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_XOR     = 6'b100110;
    localparam logic [5:0] FN_NOR     = 6'b100111;
    localparam logic [5:0] FN_SLT     = 6'b101010;
    localparam logic [5:0] FN_SLTU    = 6'b101011;

    // REGIMM rt and COP0 rs codes
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;
    localparam logic [4:0] RS_MF      = 5'b00000;
    localparam logic [4:0] RS_MT      = 5'b00100;
    localparam logic [INST_W-1:0] INST_ERET = 32'h4200_0018;

    // alucontrol codes
    localparam logic [7:0] EXE_NOP_OP     = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP     = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP      = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP     = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP     = 8'b0010_0111;
    localparam logic [7:0] EXE_ANDI_OP    = 8'b0101_1001;
    localparam logic [7:0] EXE_ORI_OP     = 8'b0101_1010;
    localparam logic [7:0] EXE_XORI_OP    = 8'b0101_1011;
    localparam logic [7:0] EXE_LUI_OP     = 8'b0101_1100;
    localparam logic [7:0] EXE_SLL_OP     = 8'b0111_1100;
    localparam logic [7:0] EXE_SLLV_OP    = 8'b0000_0100;
    localparam logic [7:0] EXE_SRL_OP     = 8'b0000_0010;
    localparam logic [7:0] EXE_SRLV_OP    = 8'b0000_0110;
    localparam logic [7:0] EXE_SRA_OP     = 8'b0000_0011;
    localparam logic [7:0] EXE_SRAV_OP    = 8'b0000_0111;
    localparam logic [7:0] EXE_MOVZ_OP    = 8'b0000_1010;
    localparam logic [7:0] EXE_MOVN_OP    = 8'b0000_1011;
    localparam logic [7:0] EXE_MFHI_OP    = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP    = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP    = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP    = 8'b0001_0011;
    localparam logic [7:0] EXE_SLT_OP     = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP    = 8'b0010_1011;
    localparam logic [7:0] EXE_SLTI_OP    = 8'b0101_0111;
    localparam logic [7:0] EXE_SLTIU_OP   = 8'b0101_1000;
    localparam logic [7:0] EXE_ADD_OP     = 8'b0010_0000;
    localparam logic [7:0] EXE_ADDU_OP    = 8'b0010_0001;
    localparam logic [7:0] EXE_SUB_OP     = 8'b0010_0010;
    localparam logic [7:0] EXE_SUBU_OP    = 8'b0010_0011;
    localparam logic [7:0] EXE_ADDI_OP    = 8'b0101_0101;
    localparam logic [7:0] EXE_ADDIU_OP   = 8'b0101_0110;
    localparam logic [7:0] EXE_MULT_OP    = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP   = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP     = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP    = 8'b0001_1011;
    localparam logic [7:0] EXE_J_OP       = 8'b0100_1111;
    localparam logic [7:0] EXE_JAL_OP     = 8'b0101_0000;
    localparam logic [7:0] EXE_JALR_OP    = 8'b0000_1001;
    localparam logic [7:0] EXE_JR_OP      = 8'b0000_1000;
    localparam logic [7:0] EXE_BEQ_OP     = 8'b0101_0001;
    localparam logic [7:0] EXE_BGEZ_OP    = 8'b0100_0001;
    localparam logic [7:0] EXE_BGEZAL_OP  = 8'b0100_1011;
    localparam logic [7:0] EXE_BGTZ_OP    = 8'b0101_0100;
    localparam logic [7:0] EXE_BLEZ_OP    = 8'b0101_0011;
    localparam logic [7:0] EXE_BLTZ_OP    = 8'b0100_0000;
    localparam logic [7:0] EXE_BLTZAL_OP  = 8'b0100_1010;
    localparam logic [7:0] EXE_BNE_OP     = 8'b0101_0010;
    localparam logic [7:0] EXE_LB_OP      = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP     = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP      = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP     = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP      = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP      = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP      = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP      = 8'b1110_1011;
    localparam logic [7:0] EXE_SYSCALL_OP = 8'b0000_1100;
    localparam logic [7:0] EXE_BREAK_OP   = 8'b0000_1101;
    localparam logic [7:0] EXE_MFC0_OP    = 8'b0101_1101;
    localparam logic [7:0] EXE_MTC0_OP    = 8'b0110_0000;
    localparam logic [7:0] EXE_ERET_OP    = 8'b0110_1011;

    typedef struct packed {
        logic [DEC_ALU_W-1:0] alucontrol;
        logic                 is_branch;
        logic                 is_mem;
        logic                 ri;
    } dec_t;

endpackage

// File: rtl/alu_dec_core.sv
// Pure combinational MIPS instruction decoder: inst -> {alucontrol, is_branch, is_mem, ri}.
//   i_inst  : raw 32-bit instruction word
//   o_dec   : decoded payload (dec_t)
// Build option ALU_DEC_RI_EN: when defined, unknown encodings raise ri; otherwise ri is 0.
module alu_dec_core
    import alu_dec_queue_pkg::*;
(
    input  logic [INST_W-1:0] i_inst,
    output dec_t              o_dec
);

`ifdef ALU_DEC_RI_EN
    localparam logic RI_EN = 1'b1;
`else
    localparam logic RI_EN = 1'b0;
`endif

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [5:0] w_funct;

    assign w_op    = i_inst[31:26];
    assign w_rs    = i_inst[25:21];
    assign w_rt    = i_inst[20:16];
    assign w_funct = i_inst[5:0];

    // Decode; all-zero word is the architectural NOP and stays at defaults
    always_comb begin
        o_dec = '0;
        if (i_inst != '0) begin
            case (w_op)
                OP_SPECIAL: begin
                    case (w_funct)
                        FN_AND:     o_dec.alucontrol = EXE_AND_OP;
                        FN_OR:      o_dec.alucontrol = EXE_OR_OP;
                        FN_XOR:     o_dec.alucontrol = EXE_XOR_OP;
                        FN_NOR:     o_dec.alucontrol = EXE_NOR_OP;
                        FN_SLL:     o_dec.alucontrol = EXE_SLL_OP;
                        FN_SRL:     o_dec.alucontrol = EXE_SRL_OP;
                        FN_SRA:     o_dec.alucontrol = EXE_SRA_OP;
                        FN_SLLV:    o_dec.alucontrol = EXE_SLLV_OP;
                        FN_SRLV:    o_dec.alucontrol = EXE_SRLV_OP;
                        FN_SRAV:    o_dec.alucontrol = EXE_SRAV_OP;
                        FN_MOVZ:    o_dec.alucontrol = EXE_MOVZ_OP;
                        FN_MOVN:    o_dec.alucontrol = EXE_MOVN_OP;
                        FN_MFHI:    o_dec.alucontrol = EXE_MFHI_OP;
                        FN_MTHI:    o_dec.alucontrol = EXE_MTHI_OP;
                        FN_MFLO:    o_dec.alucontrol = EXE_MFLO_OP;
                        FN_MTLO:    o_dec.alucontrol = EXE_MTLO_OP;
                        FN_ADD:     o_dec.alucontrol = EXE_ADD_OP;
                        FN_ADDU:    o_dec.alucontrol = EXE_ADDU_OP;
                        FN_SUB:     o_dec.alucontrol = EXE_SUB_OP;
                        FN_SUBU:    o_dec.alucontrol = EXE_SUBU_OP;
                        FN_SLT:     o_dec.alucontrol = EXE_SLT_OP;
                        FN_SLTU:    o_dec.alucontrol = EXE_SLTU_OP;
                        FN_MULT:    o_dec.alucontrol = EXE_MULT_OP;
                        FN_MULTU:   o_dec.alucontrol = EXE_MULTU_OP;
                        FN_DIV:     o_dec.alucontrol = EXE_DIV_OP;
                        FN_DIVU:    o_dec.alucontrol = EXE_DIVU_OP;
                        FN_SYSCALL: o_dec.alucontrol = EXE_SYSCALL_OP;
                        FN_BREAK:   o_dec.alucontrol = EXE_BREAK_OP;
                        FN_JR: begin
                            o_dec.alucontrol = EXE_JR_OP;
                            o_dec.is_branch  = 1'b1;
                        end
                        FN_JALR: begin
                            o_dec.alucontrol = EXE_JALR_OP;
                            o_dec.is_branch  = 1'b1;
                        end
                        default:    o_dec.ri = RI_EN;
                    endcase
                end
                OP_REGIMM: begin
                    o_dec.is_branch = 1'b1;
                    case (w_rt)
                        RT_BLTZ:   o_dec.alucontrol = EXE_BLTZ_OP;
                        RT_BGEZ:   o_dec.alucontrol = EXE_BGEZ_OP;
                        RT_BLTZAL: o_dec.alucontrol = EXE_BLTZAL_OP;
                        RT_BGEZAL: o_dec.alucontrol = EXE_BGEZAL_OP;
                        default: begin
                            o_dec.is_branch = 1'b0;
                            o_dec.ri        = RI_EN;
                        end
                    endcase
                end
                OP_COP0: begin
                    if (w_rs == RS_MF) begin
                        o_dec.alucontrol = EXE_MFC0_OP;
                    end else if (w_rs == RS_MT) begin
                        o_dec.alucontrol = EXE_MTC0_OP;
                    end else if (i_inst == INST_ERET) begin
                        o_dec.alucontrol = EXE_ERET_OP;
                    end else begin
                        o_dec.ri = RI_EN;
                    end
                end
                OP_ANDI:  o_dec.alucontrol = EXE_ANDI_OP;
                OP_ORI:   o_dec.alucontrol = EXE_ORI_OP;
                OP_XORI:  o_dec.alucontrol = EXE_XORI_OP;
                OP_LUI:   o_dec.alucontrol = EXE_LUI_OP;
                OP_ADDI:  o_dec.alucontrol = EXE_ADDI_OP;
                OP_ADDIU: o_dec.alucontrol = EXE_ADDIU_OP;
                OP_SLTI:  o_dec.alucontrol = EXE_SLTI_OP;
                OP_SLTIU: o_dec.alucontrol = EXE_SLTIU_OP;
                OP_J:     begin o_dec.alucontrol = EXE_J_OP;    o_dec.is_branch = 1'b1; end
                OP_JAL:   begin o_dec.alucontrol = EXE_JAL_OP;  o_dec.is_branch = 1'b1; end
                OP_BEQ:   begin o_dec.alucontrol = EXE_BEQ_OP;  o_dec.is_branch = 1'b1; end
                OP_BNE:   begin o_dec.alucontrol = EXE_BNE_OP;  o_dec.is_branch = 1'b1; end
                OP_BLEZ:  begin o_dec.alucontrol = EXE_BLEZ_OP; o_dec.is_branch = 1'b1; end
                OP_BGTZ:  begin o_dec.alucontrol = EXE_BGTZ_OP; o_dec.is_branch = 1'b1; end
                OP_LB:    begin o_dec.alucontrol = EXE_LB_OP;   o_dec.is_mem = 1'b1; end
                OP_LBU:   begin o_dec.alucontrol = EXE_LBU_OP;  o_dec.is_mem = 1'b1; end
                OP_LH:    begin o_dec.alucontrol = EXE_LH_OP;   o_dec.is_mem = 1'b1; end
                OP_LHU:   begin o_dec.alucontrol = EXE_LHU_OP;  o_dec.is_mem = 1'b1; end
                OP_LW:    begin o_dec.alucontrol = EXE_LW_OP;   o_dec.is_mem = 1'b1; end
                OP_SB:    begin o_dec.alucontrol = EXE_SB_OP;   o_dec.is_mem = 1'b1; end
                OP_SH:    begin o_dec.alucontrol = EXE_SH_OP;   o_dec.is_mem = 1'b1; end
                OP_SW:    begin o_dec.alucontrol = EXE_SW_OP;   o_dec.is_mem = 1'b1; end
                default:  o_dec.ri = RI_EN;
            endcase
        end
    end

endmodule

// File: rtl/alu_dec_queue.sv
// Buffered ALU decode queue: decodes fetched {pc, inst} words and holds the decoded
// entries in a DEPTH-entry FIFO feeding execute.
//   clk, resetn          : clock, async active-low reset
//   flush                : synchronous discard of all entries (wins over push/pop)
//   in_valid/in_ready    : producer handshake; in_inst/in_pc payload
//   out_valid/out_ready  : consumer handshake; out_alucontrol/out_pc/out_is_branch/
//                          out_is_mem/out_ri describe the head entry (0 while empty)
//   count                : occupancy
// Build option ALU_DEC_RI_EN enables reserved-instruction flagging in the decoder.
module alu_dec_queue
    import alu_dec_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ALUCTRL_W = 8,
    parameter int unsigned PC_W      = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INST_W-1:0]      in_inst,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ALUCTRL_W-1:0]   out_alucontrol,
    output logic [PC_W-1:0]        out_pc,
    output logic                   out_is_branch,
    output logic                   out_is_mem,
    output logic                   out_ri,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    dec_t             r_dec [DEPTH];
    logic [PC_W-1:0]  r_pc  [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    dec_t             w_in_dec;
    dec_t             w_head;

    alu_dec_core u_core (
        .i_inst (in_inst),
        .o_dec  (w_in_dec)
    );

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full && !flush;
    assign w_pop   = !w_empty && out_ready && !flush;

    // Occupancy update; flush overrides any handshake in the same cycle
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Entry storage (data only, not reset)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_dec[r_wr_ptr] <= w_in_dec;
            r_pc[r_wr_ptr]  <= in_pc;
        end
    end

    assign w_head         = r_dec[r_rd_ptr];
    assign in_ready       = !w_full;
    assign out_valid      = !w_empty;
    assign count          = r_count;
    assign out_alucontrol = out_valid ? ALUCTRL_W'(w_head.alucontrol) : '0;
    assign out_pc         = out_valid ? r_pc[r_rd_ptr] : '0;
    assign out_is_branch  = out_valid && w_head.is_branch;
    assign out_is_mem     = out_valid && w_head.is_mem;
    assign out_ri         = out_valid && w_head.ri;

endmodule
